// File: rtl/bypass_arb_pkg.sv
// Shared definitions for bypass-wire schedulers.
// Contents:
//   MAX_REQ / MAX_PTRW : widest requester vector and pointer the helpers handle
//   rr_pick_t          : result of a round-robin selection (found flag, index, one-hot)
//   ptr_inc()          : advance a round-robin pointer, wrapping at nreq (not 2^width)
//   rr_select()        : round-robin priority select (rotate, find-first, unrotate)
package bypass_arb_pkg;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_PTRW = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_PTRW-1:0] idx;
        logic [MAX_REQ-1:0]  onehot;
    } rr_pick_t;

    // Next pointer after index cur; wraps at nreq so non-power-of-2 sizes work.
    function automatic logic [MAX_PTRW-1:0] ptr_inc(input logic [MAX_PTRW-1:0] cur,
                                                    input int unsigned         nreq);
        logic [31:0] sum;
        sum = 32'(cur) + 32'd1;
        if (sum >= nreq) begin
            sum = 32'd0;
        end else begin
            sum = sum;
        end
        return sum[MAX_PTRW-1:0];
    endfunction

    // First set bit of valid at or after cur, scanning modulo nreq.
    function automatic rr_pick_t rr_select(input logic [MAX_REQ-1:0]  valid,
                                           input logic [MAX_PTRW-1:0] cur,
                                           input int unsigned         nreq);
        rr_pick_t           res;
        logic [MAX_REQ-1:0] rot;
        logic [31:0]        pos;
        logic [31:0]        first;
        res.found  = 1'b0;
        res.idx    = {MAX_PTRW{1'b0}};
        res.onehot = {MAX_REQ{1'b0}};
        rot        = {MAX_REQ{1'b0}};
        first      = 32'd0;
        // Rotate: bit k of rot is requester (cur + k) mod nreq.
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(cur) + 32'(k);
            if (pos >= nreq) begin
                pos = pos - nreq;
            end else begin
                pos = pos;
            end
            if (k < nreq) begin
                rot[k] = valid[pos[MAX_PTRW-1:0]];
            end else begin
                rot[k] = 1'b0;
            end
        end
        // Find-first: scanning downward lets the lowest set bit win without a break.
        for (int unsigned k = MAX_REQ; k > 0; k--) begin
            if (rot[k-1]) begin
                first     = 32'(k - 1);
                res.found = 1'b1;
            end else begin
                first = first;
            end
        end
        // Unrotate back to a requester index.
        pos = 32'(cur) + first;
        if (pos >= nreq) begin
            pos = pos - nreq;
        end else begin
            pos = pos;
        end
        if (res.found) begin
            res.idx                          = pos[MAX_PTRW-1:0];
            res.onehot[pos[MAX_PTRW-1:0]]    = 1'b1;
        end else begin
            res.idx = {MAX_PTRW{1'b0}};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-from-pointer selector.
// Ports:
//   req_valid [NREQ] : pending requests
//   ptr       [PTRW] : highest-priority requester this cycle
//   enable           : when low, no grant is produced
//   grant     [NREQ] : one-hot winner, or zero
//   winner    [PTRW] : encoded winner index (0 when no grant)
module rr_pick
    import bypass_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PTRW-1:0] ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PTRW-1:0] winner
);

    rr_pick_t pick_s;

    // Round-robin select, gated by enable.
    always_comb begin
        pick_s = rr_select(MAX_REQ'(req_valid), MAX_PTRW'(ptr), NREQ);
        if (enable && pick_s.found) begin
            grant  = NREQ'(pick_s.onehot);
            winner = PTRW'(pick_s.idx);
        end else begin
            grant  = {NREQ{1'b0}};
            winner = {PTRW{1'b0}};
        end
    end

endmodule

// File: rtl/bypass_rr_arbiter.sv
// Round-robin arbiter sharing one registered bypass wire among NREQ
// writeback requesters. At most one requester is granted per cycle; its
// payload appears on WVAL with WVALID one cycle later.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   req_valid [NREQ]   : request pending per requester
//   req_data  [NREQ*width] : payload i in bits [i*width +: width]
//   req_grant [NREQ]   : combinational one-hot accept (zero on flush/RST/idle)
//   flush              : suppresses all grants this cycle
//   WVAL [width]       : registered bypass payload (holds when no grant)
//   WVALID             : registered, WVAL was granted last cycle
//   ptr [PTRW]         : round-robin priority pointer
module bypass_rr_arbiter
    import bypass_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int width = 64,
    parameter int PTRW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*width-1:0] req_data,
    output logic [NREQ-1:0]       req_grant,
    input  logic                  flush,
    output logic [width-1:0]      WVAL,
    output logic                  WVALID,
    output logic [PTRW-1:0]       ptr
);

    logic [PTRW-1:0]  ptr_r;
    logic [width-1:0] wval_r;
    logic             wvalid_r;
    logic [NREQ-1:0]  grant_s;
    logic [PTRW-1:0]  winner_s;
    logic             grant_any_s;
    logic             enable_s;
    logic [width-1:0] sel_data_s;

    // Reset and flush both block any acceptance in the current cycle.
    assign enable_s = ~RST & ~flush;

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_r),
        .enable    (enable_s),
        .grant     (grant_s),
        .winner    (winner_s)
    );

    assign grant_any_s = |grant_s;

    // AND-OR payload mux keyed directly on the one-hot grant.
    always_comb begin
        sel_data_s = {width{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | ({width{grant_s[i]}} & req_data[i*width +: width]);
        end
    end

    // Pointer and output registers; WVAL holds across idle cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r    <= {PTRW{1'b0}};
            wval_r   <= {width{1'b0}};
            wvalid_r <= 1'b0;
        end else if (grant_any_s) begin
            ptr_r    <= PTRW'(ptr_inc(MAX_PTRW'(winner_s), NREQ));
            wval_r   <= sel_data_s;
            wvalid_r <= 1'b1;
        end else begin
            wvalid_r <= 1'b0;
        end
    end

    assign req_grant = grant_s;
    assign WVAL      = wval_r;
    assign WVALID    = wvalid_r;
    assign ptr       = ptr_r;

endmodule

// File: tb/tb_bypass_rr_arbiter.sv
// Self-checking bench for bypass_rr_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_bypass_rr_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           CLK;
    logic           RST;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_grant;
    logic           flush;
    logic [W-1:0]   WVAL;
    logic           WVALID;
    logic [1:0]     ptr;

    // Three-requester build for the non-power-of-2 wrap.
    logic [2:0]     req_valid3;
    logic [23:0]    req_data3;
    logic [2:0]     req_grant3;
    logic           flush3;
    logic [7:0]     wval3;
    logic           wvalid3;
    logic [1:0]     ptr3;

    int checks;
    int errors;

    // Behavioural model state
    int         m_ptr;
    logic [W-1:0] m_wval;
    logic       m_wvalid;
    logic [N-1:0] exp_grant;
    int         exp_w;

    bypass_rr_arbiter #(.NREQ(N), .width(W)) u_dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_grant(req_grant), .flush(flush), .WVAL(WVAL), .WVALID(WVALID), .ptr(ptr)
    );

    bypass_rr_arbiter #(.NREQ(3), .width(8)) u_dut3 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid3), .req_data(req_data3),
        .req_grant(req_grant3), .flush(flush3), .WVAL(wval3), .WVALID(wvalid3), .ptr(ptr3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected grant: first valid requester scanning from the pointer, modulo N.
    task automatic model_eval();
        exp_grant = '0;
        exp_w = -1;
        if (!flush && !RST) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (exp_w < 0 && req_valid[idx]) begin
                    exp_w = idx;
                    exp_grant[idx] = 1'b1;
                end
            end
        end
    endtask

    // Clock one edge, update the model as the edge does, land on the negedge.
    task automatic advance();
        model_eval();
        @(posedge CLK);
        if (RST) begin
            m_ptr = 0; m_wvalid = 1'b0; m_wval = '0;
        end else if (exp_w >= 0) begin
            m_wval = req_data[exp_w*W +: W];
            m_wvalid = 1'b1;
            m_ptr = (exp_w + 1) % N;
        end else begin
            m_wvalid = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = 4'b1111; flush = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 64'(i + 16);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (req_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", req_grant); end
            advance();
            checks++;
            if (WVALID !== 1'b0 || WVAL !== 64'd0 || ptr !== 2'd0) begin
                errors++; $display("FAIL reset_outputs: WVALID=%b WVAL=%h ptr=%0d want 0/0/0", WVALID, WVAL, ptr);
            end
        end
        RST = 1'b0;
        #1;
        checks++;
        if (req_grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", req_grant); end
        req_valid = 4'b0000;
        advance();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_data[2*W +: W] = 64'hA5;
        #1;
        checks++;
        if (req_grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_grant); end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (WVALID !== 1'b1 || WVAL !== 64'hA5 || ptr !== 2'd3) begin
            errors++; $display("FAIL single_out: WVALID=%b WVAL=%h ptr=%0d want 1/a5/3", WVALID, WVAL, ptr);
        end
    endtask

    task automatic test_contention();
        RST = 1'b1; req_valid = 4'b0000;
        advance();
        RST = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 64'(i);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] want;
            want = 4'b0001 << (c % N);
            #1;
            checks++;
            if (req_grant !== want) begin errors++; $display("FAIL contention_grant[%0d]: got %b want %b", c, req_grant, want); end
            advance();
            checks++;
            if (WVALID !== 1'b1 || WVAL !== 64'(c % N)) begin
                errors++; $display("FAIL contention_out[%0d]: WVALID=%b WVAL=%0d want 1/%0d", c, WVALID, WVAL, c % N);
            end
        end
        req_valid = 4'b0000;
        advance();
    endtask

    task automatic test_wrap_skip();
        // Grant 2 moves ptr to 3, then only requester 1 is pending.
        req_valid = 4'b0100;
        advance();
        req_valid = 4'b0010;
        req_data[1*W +: W] = 64'h1111;
        #1;
        checks++;
        if (ptr !== 2'd3 || req_grant !== 4'b0010) begin
            errors++; $display("FAIL wrap_skip_grant: ptr=%0d grant=%b want 3/0010", ptr, req_grant);
        end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (ptr !== 2'd2 || WVAL !== 64'h1111) begin
            errors++; $display("FAIL wrap_skip_ptr: ptr=%0d WVAL=%h want 2/1111", ptr, WVAL);
        end
        // NREQ=3: grant 1 (ptr->2), then grant 2 must wrap ptr to 0.
        req_data3 = 24'h33_22_11;
        req_valid3 = 3'b010;
        advance();
        req_valid3 = 3'b100;
        #1;
        checks++;
        if (ptr3 !== 2'd2 || req_grant3 !== 3'b100) begin
            errors++; $display("FAIL nreq3_grant: ptr=%0d grant=%b want 2/100", ptr3, req_grant3);
        end
        advance();
        req_valid3 = 3'b000;
        checks++;
        if (ptr3 !== 2'd0 || wvalid3 !== 1'b1 || wval3 !== 8'h33) begin
            errors++; $display("FAIL nreq3_wrap: ptr=%0d WVALID=%b WVAL=%h want 0/1/33", ptr3, wvalid3, wval3);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] held;
        logic [1:0]   held_ptr;
        req_data[0*W +: W] = 64'hF00D;
        req_data[3*W +: W] = 64'hBEEF;
        req_valid = 4'b1000;
        advance();                       // grant to 3 at t-1
        req_valid = 4'b0001;
        flush = 1'b1;
        held = WVAL; held_ptr = ptr;
        #1;
        checks++;
        if (req_grant !== 4'b0000 || WVALID !== 1'b1 || WVAL !== 64'hBEEF) begin
            errors++; $display("FAIL flush_cycle: grant=%b WVALID=%b WVAL=%h want 0000/1/beef", req_grant, WVALID, WVAL);
        end
        advance();
        flush = 1'b0;
        checks++;
        if (WVALID !== 1'b0 || WVAL !== held || ptr !== held_ptr) begin
            errors++; $display("FAIL flush_after: WVALID=%b WVAL=%h ptr=%0d want 0/%h/%0d", WVALID, WVAL, ptr, held, held_ptr);
        end
        #1;
        checks++;
        if (req_grant !== 4'b0001) begin errors++; $display("FAIL flush_release: got %b want 0001", req_grant); end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (WVALID !== 1'b1 || WVAL !== 64'hF00D) begin
            errors++; $display("FAIL flush_release_out: WVALID=%b WVAL=%h want 1/f00d", WVALID, WVAL);
        end
    endtask

    task automatic test_reset_midstream();
        RST = 1'b1;
        advance();
        RST = 1'b0;
        req_data[1*W +: W] = 64'h0101;
        req_data[3*W +: W] = 64'h0303;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_grant !== 4'b0010) begin errors++; $display("FAIL midreset_grant1: got %b want 0010", req_grant); end
        advance();
        req_valid = 4'b1000;
        RST = 1'b1;
        #1;
        checks++;
        if (req_grant !== 4'b0000) begin errors++; $display("FAIL midreset_grant_rst: got %b want 0000", req_grant); end
        advance();
        RST = 1'b0;
        checks++;
        if (WVALID !== 1'b0 || ptr !== 2'd0 || WVAL !== 64'd0) begin
            errors++; $display("FAIL midreset_out: WVALID=%b ptr=%0d WVAL=%h want 0/0/0", WVALID, ptr, WVAL);
        end
        #1;
        checks++;
        if (req_grant !== 4'b1000) begin errors++; $display("FAIL midreset_serve3: got %b want 1000", req_grant); end
        advance();
        req_valid = 4'b0000;
        checks++;
        if (WVALID !== 1'b1 || WVAL !== 64'h0303) begin
            errors++; $display("FAIL midreset_serve3_out: WVALID=%b WVAL=%h want 1/0303", WVALID, WVAL);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            RST = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) req_data[i*W +: W] = {$urandom, $urandom};
            #1;
            model_eval();
            checks++;
            if (req_grant !== exp_grant) begin
                errors++; $display("FAIL random_grant[%0d]: got %b want %b", c, req_grant, exp_grant);
            end
            advance();
            checks++;
            if (WVALID !== m_wvalid || WVAL !== m_wval || ptr !== 2'(m_ptr)) begin
                errors++; $display("FAIL random_out[%0d]: WVALID=%b WVAL=%h ptr=%0d want %b/%h/%0d",
                                   c, WVALID, WVAL, ptr, m_wvalid, m_wval, m_ptr);
            end
        end
        RST = 1'b0; flush = 1'b0; req_valid = 4'b0000;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_ptr = 0; m_wval = '0; m_wvalid = 1'b0;
        RST = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0;
        req_valid3 = '0; req_data3 = '0; flush3 = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_contention();
        test_wrap_skip();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
